// File: rtl/fare_check_if.sv
// Tap/provisioning/gate signal bundle for the fare-validation stage.
// The master drives taps, loads and reduce_bal; the slave is fare_check.
interface fare_check_if #(
  parameter int unsigned ID_W  = 4,
  parameter int unsigned BAL_W = 12
);
  logic             tap_valid;
  logic [ID_W-1:0]  tap_id;
  logic             load_en;
  logic [ID_W-1:0]  load_id;
  logic [BAL_W-1:0] load_bal;
  logic             load_active;
  logic             reduce_bal;
  logic             nfc;
  logic             card_active;
  logic             fund_enough;
  logic             busy;
  logic [BAL_W-1:0] bal_out;
  logic             deduct_done;
  logic             timeout_err;

  modport master (
    output tap_valid, tap_id, load_en, load_id, load_bal, load_active, reduce_bal,
    input  nfc, card_active, fund_enough, busy, bal_out, deduct_done, timeout_err
  );

  modport slave (
    input  tap_valid, tap_id, load_en, load_id, load_bal, load_active, reduce_bal,
    output nfc, card_active, fund_enough, busy, bal_out, deduct_done, timeout_err
  );
endinterface

// File: rtl/fare_check.sv
// Fare-validation stage: card-account table, tap lookup, and a single fare
// deduction per tap on the gate's reduce_bal rising edge.
module fare_check #(
  parameter int unsigned NUM_CARDS = 16,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned BAL_W     = 12,
  parameter int unsigned FARE      = 300,
  parameter int unsigned TIMEOUT   = 15
) (
  input logic         clk,
  input logic         reset,
  fare_check_if.slave bus
);

  localparam int unsigned      CntW     = $clog2(TIMEOUT + 1);
  localparam logic [BAL_W-1:0] FareW    = BAL_W'(FARE);
  localparam logic [CntW-1:0]  TimeoutW = CntW'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StLookup, StPresent, StHold, StDeduct} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  cur_id_q, cur_id_d;
  logic [CntW-1:0]  cnt_q, cnt_d, hold_cnt;
  logic             reduce_q;
  logic             card_active_q, card_active_d;
  logic             fund_enough_q, fund_enough_d;
  logic [BAL_W-1:0] bal_out_q, bal_out_d;

  logic [NUM_CARDS-1:0] act_q;
  logic [BAL_W-1:0]     bal_q [NUM_CARDS];

  logic             tbl_we;
  logic [ID_W-1:0]  tbl_waddr;
  logic [BAL_W-1:0] tbl_wbal;
  logic             tbl_wact;
  logic             rise, eligible;

  always_comb begin
    state_d       = state_q;
    cur_id_d      = cur_id_q;
    cnt_d         = cnt_q;
    card_active_d = card_active_q;
    fund_enough_d = fund_enough_q;
    bal_out_d     = bal_out_q;
    tbl_we        = 1'b0;
    tbl_waddr     = bus.load_id;
    tbl_wbal      = bus.load_bal;
    tbl_wact      = bus.load_active;
    hold_cnt      = cnt_q + CntW'(1);
    rise          = bus.reduce_bal & ~reduce_q;
    eligible      = card_active_q & fund_enough_q;
    bus.nfc         = 1'b0;
    bus.busy        = 1'b1;
    bus.deduct_done = 1'b0;
    bus.timeout_err = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.busy = 1'b0;
        tbl_we   = bus.load_en;
        if (bus.tap_valid) begin
          cur_id_d = bus.tap_id;
          state_d  = StLookup;
        end
      end
      StLookup: begin
        card_active_d = act_q[cur_id_q];
        fund_enough_d = act_q[cur_id_q] & (bal_q[cur_id_q] >= FareW);
        bal_out_d     = bal_q[cur_id_q];
        state_d       = StPresent;
      end
      StPresent: begin
        bus.nfc = 1'b1;
        cnt_d   = '0;
        state_d = StHold;
      end
      StHold: begin
        cnt_d = hold_cnt;
        // A rising edge wins over an expiring count in the same cycle.
        if (rise && eligible) begin
          bal_out_d = bal_out_q - FareW;
          state_d   = StDeduct;
        end else if (hold_cnt == TimeoutW) begin
          bus.timeout_err = eligible;
          card_active_d   = 1'b0;
          fund_enough_d   = 1'b0;
          state_d         = StIdle;
        end
      end
      StDeduct: begin
        bus.deduct_done = 1'b1;
        tbl_we          = 1'b1;
        tbl_waddr       = cur_id_q;
        tbl_wbal        = bal_out_q;
        tbl_wact        = card_active_q;
        card_active_d   = 1'b0;
        fund_enough_d   = 1'b0;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cur_id_q      <= '0;
      cnt_q         <= '0;
      reduce_q      <= 1'b0;
      card_active_q <= 1'b0;
      fund_enough_q <= 1'b0;
      bal_out_q     <= '0;
      act_q         <= '0;
      for (int i = 0; i < NUM_CARDS; i++) begin
        bal_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cur_id_q      <= cur_id_d;
      cnt_q         <= cnt_d;
      reduce_q      <= bus.reduce_bal;
      card_active_q <= card_active_d;
      fund_enough_q <= fund_enough_d;
      bal_out_q     <= bal_out_d;
      if (tbl_we) begin
        act_q[tbl_waddr] <= tbl_wact;
        bal_q[tbl_waddr] <= tbl_wbal;
      end
    end
  end

  assign bus.card_active = card_active_q;
  assign bus.fund_enough = fund_enough_q;
  assign bus.bal_out     = bal_out_q;

endmodule

// File: tb/tb_fare_check.sv
// Scoreboard bench for fare_check: driver pushes expected events from an
// account-level model, a negedge monitor pops and compares them.
module tb_fare_check;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fare_check_if #(.ID_W(4), .BAL_W(12)) bus ();

  fare_check #(
    .NUM_CARDS(16), .ID_W(4), .BAL_W(12), .FARE(300), .TIMEOUT(15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // kind: 0 = nfc, 1 = deduct_done, 2 = timeout_err
  typedef struct {
    int kind;
    int cyc;
    bit ca;
    bit fe;
    int bal;
  } ev_t;

  ev_t expq[$];
  bit  mact[16];
  int  mbal[16];

  task automatic chk_ev(input int kind);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d got ca=%0b fe=%0b bal=%0d required none",
               kind, cyc, bus.card_active, bus.fund_enough, bus.bal_out);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.ca != bus.card_active ||
          e.fe != bus.fund_enough || e.bal != int'(bus.bal_out)) begin
        failures++;
        $display("FAIL event got kind=%0d cyc=%0d ca=%0b fe=%0b bal=%0d required kind=%0d cyc=%0d ca=%0b fe=%0b bal=%0d",
                 kind, cyc, bus.card_active, bus.fund_enough, bus.bal_out,
                 e.kind, e.cyc, e.ca, e.fe, e.bal);
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.nfc === 1'b1) chk_ev(0);
    if (bus.deduct_done === 1'b1) chk_ev(1);
    if (bus.timeout_err === 1'b1) chk_ev(2);
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int c, input bit ca, input bit fe, input int bal);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.ca   = ca;
    e.fe   = fe;
    e.bal  = bal;
    expq.push_back(e);
  endtask

  task automatic check_zero(input string name);
    logic [17:0] got;
    got = {bus.nfc, bus.card_active, bus.fund_enough, bus.busy, bus.bal_out,
           bus.deduct_done, bus.timeout_err};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL %s got outputs=%h required 0", name, got);
    end
  endtask

  task automatic load(input int id, input int bal, input bit act);
    bus.load_en     = 1'b1;
    bus.load_id     = 4'(id);
    bus.load_bal    = 12'(bal);
    bus.load_active = act;
    mact[id] = act;
    mbal[id] = bal;
    next();
    bus.load_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 40) begin
      next();
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.card_active !== 1'b0 || bus.fund_enough !== 1'b0) begin
      failures++;
      $display("FAIL idle_return got busy=%0b ca=%0b fe=%0b required 0 0 0",
               bus.busy, bus.card_active, bus.fund_enough);
    end
  endtask

  // k: cycles after nfc at which reduce_bal rises (0 = never), held hlen cycles.
  task automatic txn(input int id, input bit ld, input int lid, input int lbal, input bit lact,
                     input int k, input int hlen, input bit poke, input bit rst_mid);
    int t, nfc_c, last, b;
    bit elig;
    if (ld) begin
      bus.load_en     = 1'b1;
      bus.load_id     = 4'(lid);
      bus.load_bal    = 12'(lbal);
      bus.load_active = lact;
      mact[lid] = lact;
      mbal[lid] = lbal;
    end
    bus.tap_valid = 1'b1;
    bus.tap_id    = 4'(id);
    t     = cyc;
    nfc_c = t + 2;
    b     = mbal[id];
    elig  = mact[id] && b >= 300;
    push(0, nfc_c, mact[id], elig, b);
    if (!rst_mid) begin
      if (elig && k >= 1 && k <= 15) begin
        b = b - 300;
        mbal[id] = b;
        push(1, nfc_c + k + 1, 1'b1, 1'b1, b);
      end else if (elig) begin
        push(2, nfc_c + 15, 1'b1, 1'b1, b);
      end
    end
    last = nfc_c + ((k + hlen > 16) ? k + hlen : 16);
    next();
    while (cyc <= last) begin
      bus.tap_valid   = poke && cyc == nfc_c + 1;
      bus.tap_id      = 4'($urandom);
      bus.load_en     = poke && cyc == nfc_c + 1;
      bus.load_id     = 4'(id);
      bus.load_bal    = 12'($urandom);
      bus.load_active = 1'b1;
      bus.reduce_bal  = k > 0 && cyc >= nfc_c + k && cyc < nfc_c + k + hlen;
      if (cyc == nfc_c + 1) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_in_hold got %0b required 1", bus.busy);
        end
      end
      if (rst_mid && cyc == nfc_c + 3) begin
        reset = 1'b1;
        next();
        reset = 1'b0;
        check_zero("reset_mid_op");
        for (int i = 0; i < 16; i++) begin
          mact[i] = 1'b0;
          mbal[i] = 0;
        end
        return;
      end
      next();
    end
    bus.reduce_bal = 1'b0;
    bus.tap_valid  = 1'b0;
    bus.load_en    = 1'b0;
    wait_idle();
  endtask

  function automatic int pick_bal();
    case ($urandom % 6)
      0: return 299;
      1: return 300;
      2: return 301;
      3: return 0;
      default: return int'($urandom % 4096);
    endcase
  endfunction

  initial begin
    int id, lid, k;
    reset           = 1'b1;
    bus.tap_valid   = 1'b0;
    bus.tap_id      = '0;
    bus.load_en     = 1'b0;
    bus.load_id     = '0;
    bus.load_bal    = '0;
    bus.load_active = 1'b0;
    bus.reduce_bal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mact[i] = 1'b0;
      mbal[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_zero("reset_state");

    load(3, 1000, 1'b1);
    txn(3, 0, 0, 0, 0, 3, 2, 0, 0);
    txn(3, 0, 0, 0, 0, 0, 1, 0, 0);
    load(5, 1000, 1'b0);
    txn(5, 0, 0, 0, 0, 4, 1, 0, 0);
    load(8, 299, 1'b1);
    txn(8, 0, 0, 0, 0, 2, 1, 0, 0);
    load(8, 300, 1'b1);
    txn(8, 0, 0, 0, 0, 2, 1, 0, 0);
    txn(8, 0, 0, 0, 0, 2, 1, 0, 0);
    load(9, 1000, 1'b1);
    txn(9, 0, 0, 0, 0, 0, 1, 0, 0);
    txn(9, 0, 0, 0, 0, 0, 1, 0, 0);
    load(4, 1000, 1'b1);
    txn(4, 0, 0, 0, 0, 5, 1, 1, 0);
    txn(4, 0, 0, 0, 0, 0, 1, 0, 0);
    txn(2, 1, 2, 500, 1'b1, 0, 1, 0, 0);
    load(10, 1000, 1'b1);
    txn(10, 0, 0, 0, 0, 15, 1, 0, 0);
    txn(10, 0, 0, 0, 0, 16, 2, 0, 0);
    load(11, 1000, 1'b1);
    txn(11, 0, 0, 0, 0, 0, 1, 0, 1);
    txn(11, 0, 0, 0, 0, 0, 1, 0, 0);
    txn(3, 0, 0, 0, 0, 3, 1, 0, 0);

    for (int i = 0; i < 16; i++) load(i, pick_bal(), ($urandom % 4) != 0);
    for (int n = 0; n < 90; n++) begin
      if ($urandom % 2 == 0) load(int'($urandom % 16), pick_bal(), ($urandom % 4) != 0);
      repeat ($urandom % 3) next();
      id  = int'($urandom % 16);
      lid = ($urandom % 2 == 0) ? id : int'($urandom % 16);
      k   = int'($urandom_range(0, 18));
      if ($urandom % 25 == 0)
        txn(id, 1'b0, 0, 0, 1'b0, 0, 1, 1'b0, 1'b1);
      else
        txn(id, ($urandom % 3) == 0, lid, pick_bal(), ($urandom % 4) != 0,
            k, int'($urandom_range(1, 3)), ($urandom % 4) == 0, 1'b0);
    end

    repeat (5) next();
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL pending_events got %0d outstanding required 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
